// File: rtl/seq_shifter.sv
// ---------------------------------------------------------------------------
// seq_shifter
//   Multi-cycle shift/rotate unit. The unit accepts one operation at a time
//   and shifts it by at most STEP bit positions per clock until the requested
//   amount is used up. It then presents the result until it is consumed.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   request present
//   in_ready   unit can accept a request this cycle
//   in_data    operand (WIDTH bits)
//   in_shamt   shift amount, 0..WIDTH-1
//   in_op      000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others pass-through
//   out_valid  result available
//   out_ready  consumer accepts result
//   out_data   result; keeps its last value while out_valid is low
//   busy       high while an operation is shifting or waiting to be consumed
// ---------------------------------------------------------------------------
module seq_shifter #(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 4,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  localparam logic [WIDTH-1:0] ONES = '1;

  state_e           state_q,    state_d;
  logic [WIDTH-1:0] data_q,     data_d;      // working register
  logic [WIDTH-1:0] out_data_q, out_data_d;  // result register
  logic [2:0]       op_q,       op_d;
  logic [SHW-1:0]   rem_q,      rem_d;       // bit positions still to shift
  logic             sign_q,     sign_d;      // SRA fill bit

  logic             accept;
  logic             op_legal;
  logic [SHW-1:0]   step_amt;
  logic [WIDTH-1:0] shifted;

  // in_ready is forced low while reset is asserted so no request can appear
  // to be taken during reset.
  assign in_ready  = rst_n & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign op_legal  = (in_op <= OP_ROR);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_data_q;
  assign busy      = (state_q == SHIFT) | (state_q == DONE);

  // One shift step: min(STEP, remaining) positions. Compared as int so the
  // STEP == WIDTH case (STEP not representable in SHW bits) stays correct;
  // in that case remaining is always the smaller value.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    step_amt = rem_q;
    if (int'(rem_q) > STEP) begin
      step_amt = SHW'(STEP);
    end

    shifted = data_q;
    unique case (op_q)
      OP_SLL:  shifted = data_q << step_amt;
      OP_SRL:  shifted = data_q >> step_amt;
      OP_SRA:  shifted = (data_q >> step_amt) | (sign_q ? ~(ONES >> step_amt) : '0);
      // step_amt >= 1 in SHIFT, so the complementary shift is below WIDTH.
      OP_ROL:  shifted = (data_q << step_amt) | (data_q >> (WIDTH - int'(step_amt)));
      OP_ROR:  shifted = (data_q >> step_amt) | (data_q << (WIDTH - int'(step_amt)));
      default: shifted = data_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    out_data_d = out_data_q;
    op_d       = op_q;
    rem_d      = rem_q;
    sign_d     = sign_q;

    unique case (state_q)
      IDLE: ;
      SHIFT: begin
        data_d = shifted;
        rem_d  = rem_q - step_amt;
        if (rem_q == step_amt) begin
          state_d    = DONE;
          out_data_d = shifted;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new request overrides the above; in DONE this is the back-to-back
    // case where the old result is consumed on the same edge.
    if (accept) begin
      data_d = in_data;
      op_d   = in_op;
      rem_d  = in_shamt;
      sign_d = (in_op == OP_SRA) ? in_data[WIDTH-1] : 1'b0;
      if ((in_shamt != '0) && op_legal) begin
        state_d = SHIFT;
      end else begin
        state_d    = DONE;
        out_data_d = in_data;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      data_q     <= '0;
      out_data_q <= '0;
      op_q       <= OP_SLL;
      rem_q      <= '0;
      sign_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      out_data_q <= out_data_d;
      op_q       <= op_d;
      rem_q      <= rem_d;
      sign_q     <= sign_d;
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// ---------------------------------------------------------------------------
// tb_seq_shifter
//   Directed and randomized checks of seq_shifter (WIDTH=32, STEP=4) against
//   a behavioural model of the shift/rotate rules and the latency formula.
// ---------------------------------------------------------------------------
module tb_seq_shifter;

  localparam int WIDTH = 32;
  localparam int STEP  = 4;
  localparam int SHW   = $clog2(WIDTH);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shamt;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;

  seq_shifter #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference result from the plain definition of each operation.
  function automatic logic [WIDTH-1:0] ref_result(input logic [WIDTH-1:0] d,
                                                  input int sh, input logic [2:0] op);
    logic signed [WIDTH-1:0] sd;
    logic [2*WIDTH-1:0]      dd;
    sd = d;
    dd = {d, d};
    case (op)
      3'd0:    return d << sh;
      3'd1:    return d >> sh;
      3'd2:    return WIDTH'(sd >>> sh);
      3'd3:    begin dd = dd << sh; return dd[2*WIDTH-1:WIDTH]; end
      3'd4:    begin dd = dd >> sh; return dd[WIDTH-1:0]; end
      default: return d;
    endcase
  endfunction

  // Edges counted from the accept edge (inclusive) until out_valid shows.
  function automatic int ref_latency(input int sh, input logic [2:0] op);
    if (op > 3'd4 || sh == 0) return 1;
    return 1 + (sh + STEP - 1) / STEP;
  endfunction

  // Presents one request (after gap idle cycles), waits for its result,
  // checks result and latency, then holds out_ready low for hold cycles
  // checking stability. Leaves out_ready=1 so the next request can be taken
  // back-to-back.
  task automatic do_op(input logic [WIDTH-1:0] d, input int sh, input logic [2:0] op,
                       input int gap, input int hold, input string tag, output int waited);
    logic [WIDTH-1:0] exp;
    int lat;
    exp    = ref_result(d, sh, op);
    waited = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = SHW'(sh);
    in_op    = op;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_rdy"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    // Inputs changed after accept must not affect the result.
    in_data  = $urandom;
    in_shamt = SHW'($urandom);
    in_op    = 3'($urandom);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_vld"}, 64'(out_valid), 64'd1);
    check({tag, "_data"}, 64'(out_data), 64'(exp));
    check({tag, "_lat"}, 64'(lat), 64'(ref_latency(sh, op)));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_vld"}, 64'(out_valid), 64'd1);
      check({tag, "_hold_data"}, 64'(out_data), 64'(exp));
      check({tag, "_hold_rdy"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
  endtask

  initial begin
    int w;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h0000_0005;
    in_shamt  = 5'd3;
    in_op     = 3'd0;
    out_ready = 1'b1;

    // Reset with a request pending.
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy",  64'(in_ready),  64'd0);
    check("rst_vld",  64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data),  64'd0);
    check("rst_busy", 64'(busy),      64'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    check("idle_rdy", 64'(in_ready), 64'd1);

    // Zero shift, single-step shift, max-amount SRA, rotates.
    do_op(32'h0000_0001,  0, 3'd0, 0, 0, "sll0",     w);
    do_op(32'hF000_0000,  4, 3'd1, 1, 0, "srl4",     w);
    do_op(32'h8000_0000, 31, 3'd2, 0, 0, "sra_neg",  w);
    do_op(32'h7FFF_FFFF, 31, 3'd2, 2, 0, "sra_pos",  w);
    do_op(32'h1234_5678,  8, 3'd4, 0, 0, "ror8",     w);
    do_op(32'h8000_0001,  1, 3'd3, 1, 0, "rol1",     w);

    // Backpressure for 5 cycles, then a back-to-back request.
    do_op(32'h0000_00A5,  6, 3'd0, 1, 5, "bp",       w);
    do_op(32'h0000_0003,  5, 3'd0, 0, 0, "b2b",      w);
    check("b2b_nowait", 64'(w), 64'd0);

    // Illegal op passes data through in one cycle.
    do_op(32'hDEAD_BEEF,  5, 3'd7, 0, 0, "illegal",  w);

    // Reset during SHIFT discards the operation.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'hFFFF_FFFF;
    in_shamt = 5'd20;
    in_op    = 3'd1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_busy", 64'(busy), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("mid_vld", 64'(out_valid), 64'd0);
      check("mid_data", 64'(out_data), 64'd0);
      check("mid_busy0", 64'(busy), 64'd0);
      @(posedge clk);
      #1;
    end
    check("mid_rdy", 64'(in_ready), 64'd1);

    // Randomized operations with random gaps and backpressure.
    for (int i = 0; i < 40; i++) begin
      do_op($urandom, int'($urandom_range(0, WIDTH - 1)), 3'($urandom_range(0, 7)),
            int'($urandom_range(0, 1)), int'($urandom_range(0, 2)), "rand", w);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
Parametrised multi-cycle shift/rotate unit for the ALU datapath. It replaces the single-cycle combinational shifter when timing closure or area matters. Each cycle it shifts by at most STEP bit positions. It supports logical left/right, arithmetic right, rotate left and rotate right, behind valid/ready handshakes on both input and output.

Parameters:
WIDTH, 32, operand/result width in bits (>= 2)
STEP, 4, maximum bit positions shifted per cycle (1..WIDTH)
SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  request present
in_ready  output  1  unit can accept a request this cycle
in_data  input  WIDTH  operand
in_shamt  input  SHW  shift amount, 0..WIDTH-1
in_op  input  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others pass-through
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_data  output  WIDTH  result
busy  output  1  high in SHIFT or DONE

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE, out_valid=0, out_data=0, busy=0, internal remaining count=0. Reset overrides all handshakes. An in-flight operation is discarded with no output.
- States: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Accept = in_valid & in_ready.
- On accept:
  - Latch data, op, remaining=in_shamt.
  - For SRA, latch sign = in_data[WIDTH-1].
  - Next state is SHIFT if in_shamt!=0 and op is legal; otherwise DONE with the data unchanged.
- SHIFT, each cycle:
  - s = min(STEP, remaining).
  - Apply op by s to the working register.
  - SLL/SRL fill with 0. SRA fills with the latched sign. ROL/ROR wrap the bits.
  - remaining -= s. When remaining becomes 0, next state is DONE.
- DONE: out_valid=1 and out_data=working register, both held stable until out_ready.
  - out_ready=1 and in_valid=0: next state IDLE, out_valid drops.
  - out_ready=1 and in_valid=1: the new request is accepted in the same cycle (back-to-back, no bubble).
- Latency from accept edge to out_valid: 1 + ceil(shamt/STEP) cycles. shamt=0 or illegal op gives 1 cycle. Maximum is 1 + ceil((WIDTH-1)/STEP).
- Arithmetic left shift is not a separate op; SLL serves it.
- in_data, in_shamt and in_op are ignored when no accept occurs. Changing them mid-operation has no effect.
- out_data is undefined-free: it holds its last value when out_valid=0 (0 after reset).
- Never more than one operation in flight.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> in_ready=0 during reset, out_valid=0, out_data=0, busy=0. After release, in_ready=1 in IDLE.
- Zero shift and throughput: SLL 0x00000001 shamt 0 -> out_valid exactly 1 cycle after accept, out_data=0x00000001. SRL 0xF0000000 shamt 4 -> 0x0F000000, latency 2.
- SRA sign fill at maximum amount: SRA 0x80000000 shamt 31 (STEP=4) -> 0xFFFFFFFF after 9 cycles. SRA 0x7FFFFFFF shamt 31 -> 0x00000000.
- Rotates: ROR 0x12345678 shamt 8 -> 0x78123456, latency 3. ROL 0x80000001 shamt 1 -> 0x00000003, latency 2.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles in DONE -> out_data stable, in_ready=0.
  - Then raise out_ready with in_valid=1 (SLL 0x3 shamt 5) -> new request accepted the same cycle; next result 0x00000060.
- Reset mid-operation and illegal op:
  - Assert rst_n=0 during SHIFT of SRL 0xFFFFFFFF shamt 20 -> no out_valid, returns to IDLE.
  - in_op=111 with data 0xDEADBEEF -> 0xDEADBEEF after 1 cycle.
